// File: rtl/cas_div_pkg.sv
// cas_div_pkg: shared state encoding and latency helper for the sequential CAS divider.
package cas_div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    SIGN = 3'd3,
    DONE = 3'd4
  } state_t;

  // Cycle offset from the accepting start edge to the done cycle (non-zero divisor).
  function automatic int unsigned cas_div_latency(input int unsigned width, input bit signed_en);
    return signed_en ? width + 32'd3 : width + 32'd2;
  endfunction

endpackage

// File: rtl/cas_row.sv
// cas_row: N controlled add/subtract cells in a ripple chain; s = a + m (sub=0) or a - m (sub=1).
module cas_row #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] m,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         c_out
);

  logic [N:0] c;

  assign c[0] = sub;

  // One CAS cell per bit: sub inverts the m operand and supplies the carry-in.
  for (genvar i = 0; i < N; i++) begin : g_cell
    logic b;
    assign b        = m[i] ^ sub;
    assign s[i]     = a[i] ^ b ^ c[i];
    assign c[i+1]   = (a[i] & b) | (c[i] & (a[i] ^ b));
  end

  assign c_out = c[N];

endmodule

// File: rtl/seq_cas_divider.sv
// seq_cas_divider: non-restoring divider iterating one shared CAS row per clock.
// Optional feature: define CAS_DIV_SIGNED_EN for two's-complement operands (adds the SIGN step).
module seq_cas_divider
  import cas_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [RW-1:0]    r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [RW-1:0]    d_q, d_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
`ifdef CAS_DIV_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic [RW-1:0]    row_a, row_s;
  logic             row_sub;
  logic             row_c_out_unused;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

  // Operand magnitudes presented to the datapath on an accepted start.
  always_comb begin
`ifdef CAS_DIV_SIGNED_EN
    dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    dvd_mag = dividend;
    dvs_mag = divisor;
`endif
  end

  // Row operands: RUN shifts {R,Q} and adds/subtracts by the sign of R; FIX restores with +D.
  always_comb begin
    row_a   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    row_sub = ~r_q[WIDTH];
    if (state_q == FIX) begin
      row_a   = r_q;
      row_sub = 1'b0;
    end
  end

  cas_row #(.N(RW)) u_row (
    .a     (row_a),
    .m     (d_q),
    .sub   (row_sub),
    .s     (row_s),
    .c_out (row_c_out_unused)
  );

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    q_d           = q_q;
    d_d           = d_q;
    count_d       = count_q;
    dz_d          = dz_q;
`ifdef CAS_DIV_SIGNED_EN
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          d_d     = {1'b0, dvs_mag};
          dz_d    = (divisor == '0);
`ifdef CAS_DIV_SIGNED_EN
          neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            // Divide-by-zero result is staged through FIX (R is non-negative, so FIX leaves it).
            r_d     = {1'b0, dividend};
            q_d     = '1;
            state_d = FIX;
          end else begin
            r_d     = '0;
            q_d     = dvd_mag;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d     = row_s;
        q_d     = {q_q[WIDTH-2:0], ~row_s[WIDTH]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (r_q[WIDTH]) r_d = row_s;
`ifdef CAS_DIV_SIGNED_EN
        state_d = dz_q ? DONE : SIGN;
`else
        state_d = DONE;
`endif
      end
      SIGN: begin
`ifdef CAS_DIV_SIGNED_EN
        if (neg_quo_q) q_d = -q_q;
        if (neg_rem_q) r_d = {1'b0, -r_q[WIDTH-1:0]};
`endif
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d        = (state_d == RUN) || (state_d == FIX) || (state_d == SIGN);
    done_d        = (state_d == DONE);
    quotient_d    = done_d ? q_d : quotient_q;
    remainder_d   = done_d ? r_d[WIDTH-1:0] : remainder_q;
    div_by_zero_d = done_d ? dz_d : div_by_zero_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      r_q           <= '0;
      q_q           <= '0;
      d_q           <= '0;
      count_q       <= '0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
`ifdef CAS_DIV_SIGNED_EN
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      q_q           <= q_d;
      d_q           <= d_d;
      count_q       <= count_d;
      dz_q          <= dz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
`ifdef CAS_DIV_SIGNED_EN
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_cas_divider.sv
// tb_seq_cas_divider: directed and randomized checks of seq_cas_divider against an arithmetic model.
module tb_seq_cas_divider;

  localparam int unsigned W = 8;
`ifdef CAS_DIV_SIGNED_EN
  localparam int LAT = W + 3;
`else
  localparam int LAT = W + 2;
`endif
  localparam int LAT_DZ = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  seq_cas_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the one operation in flight by edges since acceptance.
  bit           m_active = 1'b0;
  int           m_pos    = 0;
  int           m_ldone  = 0;
  logic [W-1:0] m_q  = '0;
  logic [W-1:0] m_r  = '0;
  logic         m_dz = 1'b0;
  logic [W-1:0] p_q  = '0;
  logic [W-1:0] p_r  = '0;
  logic         p_dz = 1'b0;

  initial begin
    int sa;
    int sb;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 1'b0;
        m_q = '0; m_r = '0; m_dz = 1'b0;
      end else if (m_active) begin
        if (m_pos == m_ldone) begin
          m_active = 1'b0;
        end else begin
          m_pos++;
          if (m_pos == m_ldone) begin
            m_q = p_q; m_r = p_r; m_dz = p_dz;
          end
        end
      end else if (start) begin
        m_active = 1'b1;
        m_pos    = 0;
        if (divisor == '0) begin
          m_ldone = LAT_DZ - 1;
          p_q = '1; p_r = dividend; p_dz = 1'b1;
        end else begin
          m_ldone = LAT - 1;
          p_dz = 1'b0;
`ifdef CAS_DIV_SIGNED_EN
          sa  = int'($signed(dividend));
          sb  = int'($signed(divisor));
`else
          sa  = int'(dividend);
          sb  = int'(divisor);
`endif
          p_q = W'(sa / sb);
          p_r = W'(sa % sb);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_busy", 32'(busy), 32'(m_active && (m_pos < m_ldone)));
        check("cyc_done", 32'(done), 32'(m_active && (m_pos == m_ldone)));
        check("cyc_quotient", 32'(quotient), 32'(m_q));
        check("cyc_remainder", 32'(remainder), 32'(m_r));
        check("cyc_div_by_zero", 32'(div_by_zero), 32'(m_dz));
      end
    end
  end

  // One division with literal expectations for result, latency and busy.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat, input string tag);
    int lat;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1; seen = 1'b0; busy_ok = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    logic [W-1:0] first_q;
    logic [W-1:0] first_r;
    bit first_seen;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT, "t1_100_7");
    run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT, "t2_255_1");
    run_div(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, LAT, "t2_3_200");
    run_div(8'd0, 8'd9, 8'd0, 8'd0, 1'b0, LAT, "t2_0_9");
    run_div(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, LAT_DZ, "t3_5_0");

    // Start held high over three back-to-back divisions with operands churning.
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    dones = 0; first_seen = 1'b0; first_q = '0; first_r = '0;
    for (int i = 1; i <= 3 * (LAT + 1); i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        if (!first_seen) begin
          first_seen = 1'b1; first_q = quotient; first_r = remainder;
        end
      end
      if (i < 3 * (LAT + 1)) begin
        dividend = W'($urandom);
        divisor  = W'($urandom_range(1, 255));
      end else begin
        start = 1'b0;
      end
    end
    check("t4_done_count", 32'(dones), 32'd3);
    check("t4_first_quotient", 32'(first_q), 32'd10);
    check("t4_first_remainder", 32'(first_r), 32'd0);
    repeat (LAT + 2) @(negedge clk);

    // Reset during iteration 4 of 200/3 aborts without a done.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_quotient", 32'(quotient), 32'd0);
    check("t5_remainder", 32'(remainder), 32'd0);
    check("t5_dbz", 32'(div_by_zero), 32'd0);
    dones = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("t5_no_done", 32'(dones), 32'd0);
    run_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, LAT, "t5_9_2");

`ifdef CAS_DIV_SIGNED_EN
    run_div(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, LAT, "t6_m100_7");
    run_div(8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0, LAT, "t6_100_m7");
    run_div(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, LAT, "t6_m128_m1");
`endif

    // Randomized traffic: random start, operands, divide-by-zero and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom);
      case ($urandom_range(0, 3))
        0:       divisor = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 15));
        1:       divisor = W'($urandom_range(1, 15));
        default: divisor = W'($urandom);
      endcase
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (LAT + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
